memory_responder: RTL

Data-memory responder that serves the CPU's load/store requests over a valid/ready request channel and a valid/ready response channel. It sits on the target side of the CPU's data-memory port. It owns a word-organised storage array and performs byte, halfword and word accesses with RISC-V sign/zero extension. It models a fixed access latency so the CPU's stall logic is exercised, and flags misaligned, out-of-range and illegal accesses with an error response instead of touching storage.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/load_store_align.sv | 73 +++++++
 rtl/memory_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Encodings shared by the data-memory responder, the decoder and the CPU:
// load/store width codes (RISC-V funct3) and the responder FSM states.
package mem_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } mem_state_t;

    // Zero-extending loads have no store counterpart.
    function automatic logic is_unsigned_op(input logic [2:0] op_length);
        return (op_length == OP_BU) || (op_length == OP_HU);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering for the memory responder: load extraction and
// extension, store byte-merge into the addressed word, and access checking.
module load_store_align
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic [31:0] address,
    input  logic        write,
    input  logic [31:0] store_data,
    input  logic [2:0]  op_length,
    input  logic [31:0] mem_word,
    output logic [31:0] load_data,
    output logic [31:0] merged_word,
    output logic        error
);

    logic [1:0]  lane;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] extended;
    logic [31:0] byte_mask;
    logic [31:0] store_lanes;
    logic        misaligned;
    logic        bad_op;
    logic        out_of_range;

    assign lane         = address[1:0];
    assign sel_byte     = mem_word[{lane, 3'b000} +: 8];
    assign sel_half     = address[1] ? mem_word[31:16] : mem_word[15:0];
    assign out_of_range = ({2'b00, address[31:2]} >= DEPTH_WORDS);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        extended    = '0;
        byte_mask   = '0;
        store_lanes = '0;
        misaligned  = 1'b0;
        bad_op      = 1'b0;
        case (op_length)
            OP_B, OP_BU: begin
                extended    = (op_length == OP_B) ? {{24{sel_byte[7]}}, sel_byte}
                                                  : {24'h0, sel_byte};
                byte_mask   = 32'h0000_00FF << {lane, 3'b000};
                store_lanes = {4{store_data[7:0]}};
            end
            OP_H, OP_HU: begin
                extended    = (op_length == OP_H) ? {{16{sel_half[15]}}, sel_half}
                                                  : {16'h0, sel_half};
                byte_mask   = address[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                store_lanes = {2{store_data[15:0]}};
                misaligned  = address[0];
            end
            OP_W: begin
                extended    = mem_word;
                byte_mask   = 32'hFFFF_FFFF;
                store_lanes = store_data;
                misaligned  = |lane;
            end
            default: bad_op = 1'b1;
        endcase
        // Stores have only signed-width codes; BU/HU stores are rejected.
        if (write && is_unsigned_op(op_length)) begin
            bad_op = 1'b1;
        end
    end

    assign error       = misaligned | bad_op | out_of_range;
    assign load_data   = (error || write) ? 32'h0 : extended;
    assign merged_word = error ? mem_word
                               : ((mem_word & ~byte_mask) | (store_lanes & byte_mask));

endmodule

// File: rtl/memory_responder.sv
// Data-memory target for the CPU: one outstanding load/store at a time, a fixed
// access latency, and error responses for accesses that must not touch storage.
module memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    input  logic        req_write,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_op_length,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_error
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAST_COUNT = 4'(LATENCY - 1);

    mem_state_t  state_q;
    mem_state_t  state_d;
    logic [3:0]  count_q;
    logic        accept;
    logic        access_done;

    logic [31:0] addr_q;
    logic        write_q;
    logic [31:0] data_q;
    logic [2:0]  op_q;

    logic [31:0] resp_data_q;
    logic        resp_error_q;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic             idx_valid;
    logic [31:0]      mem_word;
    logic [31:0]      load_data;
    logic [31:0]      merged_word;
    logic             error;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        accept      = 1'b0;
        access_done = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !reset;
                if (req_valid && !reset) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (count_q == LAST_COUNT) begin
                    access_done = 1'b1;
                    state_d     = RESPOND;
                end
            end
            RESPOND: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q      <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            if (accept || access_done) begin
                count_q <= '0;
            end else if (state_q == ACCESS) begin
                count_q <= count_q + 4'd1;
            end
            // Response fields are captured once and then held through RESPOND.
            if (access_done) begin
                resp_data_q  <= load_data;
                resp_error_q <= error;
            end
        end
    end

    // Request fields are only consumed after a capture, so they need no reset value.
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q  <= req_address;
            write_q <= req_write;
            data_q  <= req_data;
            op_q    <= req_op_length;
        end
    end

    assign word_idx  = addr_q[IDX_W+1:2];
    assign idx_valid = ({2'b00, addr_q[31:2]} < DEPTH_WORDS);
    assign mem_word  = idx_valid ? mem[word_idx] : 32'h0;

    load_store_align #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_align (
        .address     (addr_q),
        .write       (write_q),
        .store_data  (data_q),
        .op_length   (op_q),
        .mem_word    (mem_word),
        .load_data   (load_data),
        .merged_word (merged_word),
        .error       (error)
    );

    // NOTE: the storage array has no reset, so it maps onto plain RAM; reset does not clear it.
    always_ff @(posedge clock) begin
        if (access_done && write_q && !error) begin
            mem[word_idx] <= merged_word;
        end
    end

    assign resp_data  = resp_data_q;
    assign resp_error = resp_error_q;

endmodule
